// File: rtl/demultiplexor_1_3_16b.sv
// demultiplexor_1_3_16b: routes a 16-bit word to one of three one-entry channel buffers or discards it
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   Data_In, Selector      word and destination (0..2 -> channel 1..3, 3 -> discard)
//   Enable, In_Valid       routing permission and input qualifier
//   In_Ready               combinational accept indication
//   OUT1..3, Valid1..3     registered channel data and occupancy
//   Ready1..3              per-channel consumer take strobes
//   Busy                   any channel occupied
//   Drop_Count             saturating discard counter, only with DEMUX_DROP_COUNT_EN defined
module demultiplexor_1_3_16b (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Data_In,
    input  logic [1:0]  Selector,
    input  logic        Enable,
    input  logic        In_Valid,
    output logic        In_Ready,
    output logic [15:0] OUT1,
    output logic [15:0] OUT2,
    output logic [15:0] OUT3,
    output logic        Valid1,
    output logic        Valid2,
    output logic        Valid3,
    input  logic        Ready1,
    input  logic        Ready2,
    input  logic        Ready3,
    output logic        Busy
`ifdef DEMUX_DROP_COUNT_EN
    ,
    output logic [7:0]  Drop_Count
`endif
);
    logic [2:0]  valid_q, valid_d, rdy;
    logic [15:0] out_q [3];
    logic [15:0] out_d [3];
    logic [3:0]  acc, slot_free;
    assign rdy = {Ready3, Ready2, Ready1};
    // Slot 3 (discard) can always take a word; a full channel frees up when drained this cycle
    assign slot_free = {1'b1, ~valid_q | rdy};
    assign In_Ready = !reset && Enable && slot_free[Selector];
    always_comb begin
        valid_d = valid_q;
        out_d = out_q;
        acc = (In_Valid && In_Ready) ? 4'b0001 << Selector : 4'b0000;
        for (int k = 0; k < 3; k++) begin
            valid_d[k] = acc[k] | (valid_q[k] & ~rdy[k]);
            out_d[k] = acc[k] ? Data_In : out_q[k];
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            out_q <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            out_q <= out_d;
        end
    end
    assign OUT1 = out_q[0];
    assign OUT2 = out_q[1];
    assign OUT3 = out_q[2];
    assign Valid1 = valid_q[0];
    assign Valid2 = valid_q[1];
    assign Valid3 = valid_q[2];
    assign Busy = |valid_q;
`ifdef DEMUX_DROP_COUNT_EN
    logic [7:0] drop_q, drop_d;
    always_comb begin
        drop_d = (acc[3] && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end
    assign Drop_Count = drop_q;
`endif
endmodule

// File: doc/demultiplexor_1_3_16b.md
DEMULTIPLEXOR_1_3_16B -- requirements
Module: Demultiplexor_1_3_16b

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 Data_In  input  16  word to be routed.
REQ-005 Selector  input  2  destination: 0 -> channel 1, 1 -> channel 2, 2 -> channel 3, 3 -> discard.
REQ-006 Enable  input  1  1 = routing permitted; 0 = no new words accepted.
REQ-007 In_Valid  input  1  Data_In/Selector valid this cycle.
REQ-008 In_Ready  output  1  block accepts the word this cycle (combinational).
REQ-009 OUT1, OUT2, OUT3  output  16 each  per-channel registered data.
REQ-010 Valid1, Valid2, Valid3  output  1 each  channel holds an undelivered word.
REQ-011 Ready1, Ready2, Ready3  input  1 each  consumer takes the word this cycle.
REQ-012 Busy  output  1  OR of Valid1..Valid3.
REQ-013 Drop_Count  output  8  discarded-word counter (present only per REQ-031).

Function
REQ-014 Each channel k SHALL be a one-entry buffer with two states, EMPTY (Valid_k=0) and FULL (Valid_k=1).
REQ-015 Accept SHALL occur when In_Valid=1 and In_Ready=1 in the same cycle.
REQ-016 In_Ready SHALL be 0 when Enable=0, whatever the other inputs.
REQ-017 With Enable=1 and Selector=3, In_Ready SHALL be 1.
REQ-018 With Enable=1 and Selector=k-1, In_Ready SHALL be 1 iff channel k is EMPTY or (Valid_k=1 and Ready_k=1) in that cycle, giving full throughput.
REQ-019 On accept to channel k, OUT_k SHALL load Data_In and Valid_k SHALL be 1 on the next cycle (latency 1).
REQ-020 Transition FULL->EMPTY SHALL occur when Valid_k=1 and Ready_k=1 and no accept targets channel k in that cycle.
REQ-021 If a drain and an accept on channel k coincide, the channel SHALL stay FULL with the new word; no word is lost or duplicated.
REQ-022 While Valid_k=1 and Ready_k=0, OUT_k SHALL hold stable.
REQ-023 When EMPTY, OUT_k SHALL hold the last delivered word; consumers SHALL qualify OUT_k with Valid_k.
REQ-024 An accept with Selector=3 SHALL change no channel state.
REQ-025 Channels SHALL be independent: a stalled channel SHALL NOT block accepts to other channels.
REQ-026 Enable=0 SHALL NOT stop channel draining; FULL channels still deliver on Ready_k.
REQ-027 Ready_k while EMPTY SHALL have no effect.

Reset
REQ-028 On reset assertion, with no clock edge required: Valid1..3=0, OUT1..3=16'h0000, Busy=0, Drop_Count=0.
REQ-029 Words buffered or in flight at reset SHALL be lost; the first accept after reset deasserts SHALL behave as from power-up.
REQ-030 In_Ready SHALL be 0 while reset=1.

Configuration
REQ-031 With macro DEMUX_DROP_COUNT_EN defined: Drop_Count SHALL increment by 1 on each accept with Selector=3 and saturate at 8'hFF.
REQ-032 Without DEMUX_DROP_COUNT_EN: the Drop_Count port SHALL be absent, the counter SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-033 After reset: In_Valid=1, Enable=1, Selector=0, Data_In=16'hA5A5 for one cycle, Ready1=1 -> next cycle Valid1=1 and OUT1=16'hA5A5; the cycle after, Valid1=0.
REQ-034 Ready2=0 held; accept 16'h1111 to channel 2, then offer 16'h2222 to channel 2 -> In_Ready=0, OUT2 stays 16'h1111; raise Ready2 -> 16'h2222 accepted the same cycle, and OUT2=16'h2222 next cycle.
REQ-035 Channel 1 stalled FULL, then offer 16'h3333 to channel 3 -> accepted; Valid3=1 and OUT3=16'h3333 next cycle, with OUT1 unchanged.
REQ-036 Enable=0 with In_Valid=1 -> In_Ready=0 and no channel changes, while a FULL channel with Ready_k=1 still drains.
REQ-037 With DEMUX_DROP_COUNT_EN, 300 accepts with Selector=3 -> Drop_Count=8'hFF and Valid1..3 remain 0.
REQ-038 Assert reset asynchronously, between clock edges, while all three channels are FULL -> Valid1..3=0, OUT1..3=0 and Busy=0 before the next edge.
